// File: rtl/vga_pkg.sv
// Shared VGA timing constants, counter width and TinyVGA PMOD bit order.
package vga_pkg;

  localparam int CNT_W = 10;

  // Default 640x480@60 timing, in pixel clocks / lines.
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  function automatic int vga_total(input int disp, input int front,
                                   input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  localparam int DEF_H_TOTAL = vga_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = vga_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

  // TinyVGA PMOD word: {hsync, b0, g0, r0, vsync, b1, g1, r1}.
  localparam int PMOD_HSYNC = 7;
  localparam int PMOD_B0    = 6;
  localparam int PMOD_G0    = 5;
  localparam int PMOD_R0    = 4;
  localparam int PMOD_VSYNC = 3;
  localparam int PMOD_B1    = 2;
  localparam int PMOD_G1    = 1;
  localparam int PMOD_R1    = 0;

  // Syncs inactive (high), colour black.
  localparam logic [7:0] PMOD_IDLE = 8'h88;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_pmod_pack.sv
// Packs syncs and (blanked) colour into the TinyVGA PMOD pin word.
module vga_pmod_pack
  import vga_pkg::*;
(
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blank,
  input  rgb_t       rgb,
  output logic [7:0] word
);

  rgb_t pix;

  // Force colour to black outside the visible area, then scatter bits to pins.
  always_comb begin
    pix              = blank ? '0 : rgb;
    word             = '0;
    word[PMOD_HSYNC] = hsync;
    word[PMOD_B0]    = pix.b[0];
    word[PMOD_G0]    = pix.g[0];
    word[PMOD_R0]    = pix.r[0];
    word[PMOD_VSYNC] = vsync;
    word[PMOD_B1]    = pix.b[1];
    word[PMOD_G1]    = pix.g[1];
    word[PMOD_R1]    = pix.r[1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, sync decode, line/frame pulses and a
// registered TinyVGA PMOD output word.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       rgb_in,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             display_on,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_count,
  output logic [7:0]       uo_out
);

  localparam int H_TOTAL = vga_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = vga_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic       h_wrap, f_wrap;
  logic       line_wrap_q, frame_wrap_q;
  logic       hsync, vsync;
  logic [7:0] pmod_word;
  rgb_t       pix_in;

  assign pix_in = rgb_in;
  assign h_wrap = (hpos == H_LAST);
  assign f_wrap = h_wrap && (vpos == V_LAST);

  // Raster counters; everything freezes while run is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos <= '0;
      vpos <= '0;
    end else if (run) begin
      hpos <= h_wrap ? '0 : hpos + 1'b1;
      if (h_wrap) vpos <= f_wrap ? '0 : vpos + 1'b1;
    end
  end

  // Remember that the last advancing edge was a wrap; reset clears it so
  // coming out of reset at (0,0) never looks like a line or frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_wrap_q  <= 1'b0;
      frame_wrap_q <= 1'b0;
    end else if (run) begin
      line_wrap_q  <= h_wrap;
      frame_wrap_q <= f_wrap;
    end
  end

  // Completed-frame counter, naturally modulo 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            frame_count <= '0;
    else if (run && f_wrap) frame_count <= frame_count + 8'd1;
  end

  // Visible-area and active-low sync decode from the registered counters.
  always_comb begin
    display_on = (hpos < H_VIS) && (vpos < V_VIS);
    hsync      = !((hpos >= HS_START) && (hpos < HS_END));
    vsync      = !((vpos >= VS_START) && (vpos < VS_END));
  end

  // Pulses are gated by run so a paused generator reports nothing.
  always_comb begin
    line_start  = run && line_wrap_q && (hpos == '0);
    frame_start = run && frame_wrap_q && (hpos == '0) && (vpos == '0);
  end

  vga_pmod_pack u_pack (
    .hsync (hsync),
    .vsync (vsync),
    .blank (!display_on),
    .rgb   (pix_in),
    .word  (pmod_word)
  );

  // Output word lags the counters by one clock, matching rgb_in sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   uo_out <= PMOD_IDLE;
    else if (run) uo_out <= pmod_word;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, h front porch
- H_SYNC, 96, h sync width
- H_BACK, 48, h back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, v front porch
- V_SYNC, 2, v sync width
- V_BACK, 33, v back porch
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  pixel clock (25.175 MHz nominal)
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  1 = counters advance; 0 = all state held
- rgb_in  in  6  {r[1:0], g[1:0], b[1:0]} for the current hpos/vpos
- hpos  out  10  current column
- vpos  out  10  current line
- display_on  out  1  hpos/vpos inside visible area
- line_start  out  1  pulse on hpos==0
- frame_start  out  1  pulse on frame wrap
- frame_count  out  8  completed-frame counter
- uo_out  out  8  TinyVGA PMOD pin word
REQ-003 Clock and reset SHALL be one clock, clk, and one reset, rst_n, asynchronous and active-low.

Function
REQ-004 H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525); both SHALL be derived, not ports.
REQ-005 With run=1: hpos SHALL increment each clk; at H_TOTAL-1 it SHALL wrap to 0 and vpos SHALL increment.
REQ-006 vpos SHALL wrap from V_TOTAL-1 to 0 on the same edge that hpos wraps.
REQ-007 With run=0: hpos, vpos, frame_count and uo_out SHALL hold; line_start and frame_start SHALL be 0.
REQ-008 display_on SHALL be 1 iff hpos<H_DISPLAY and vpos<V_DISPLAY, decoded combinationally from the registered counters.
REQ-009 Internal hsync SHALL be 0 (active, negative polarity) iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751); otherwise 1.
REQ-010 Internal vsync SHALL be 0 iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491); otherwise 1.
REQ-011 line_start SHALL be 1 in the cycle where hpos==0, run==1, and the previous edge was a wrap (not reset).
REQ-012 frame_start SHALL be 1 for exactly the one cycle after the (799,524)->(0,0) wrap, with run==1.
REQ-013 frame_count SHALL increment on that same wrap edge, modulo 256 (255->0).
REQ-014 uo_out SHALL register, 1-cycle latency, {hsync, b[0], g[0], r[0], vsync, b[1], g[1], r[1]}, with rgb forced to 0 when display_on==0.
REQ-015 rgb_in SHALL be sampled on the same edge that samples hpos/vpos; the caller's pixel logic is combinational from hpos/vpos.

Reset
REQ-016 While rst_n==0, all of the following SHALL hold:
- hpos=0, vpos=0, frame_count=0
- line_start=0, frame_start=0
- uo_out=8'h88 (syncs inactive, rgb 0)
- display_on=1 (decode of 0,0)
REQ-017 Assertion of rst_n mid-frame SHALL take effect immediately (asynchronous); deassertion SHALL resume counting from (0,0) on the next clk edge with run=1.
REQ-018 No pulse SHALL be generated by reset deassertion itself.

Structure
REQ-019 A shared package vga_pkg SHALL hold the default timing constants, derived H_TOTAL/V_TOTAL, the counter width (10), and the PMOD bit-order constants.
REQ-020 A single sub-module vga_pmod_pack (combinational: syncs, blank, rgb -> 8-bit word) SHALL be instantiated ahead of the uo_out register.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset released, run=1, 800 clks -> hpos 0..799 then 0; vpos 0->1 at clk 800; line_start at clk 800 only.
- Full frame, 420000 clks -> frame_start exactly once at (0,0); frame_count=1; uo_out[7] low 96 clks per line; uo_out[3] low for 2 lines (1600 clks).
- rgb_in=6'b111111 -> uo_out=8'hFF-style pattern in visible area (syncs 1); uo_out rgb bits 0 at hpos 640..799 and vpos >= 480.
- run=0 for 50 clks at hpos=300 -> hpos stays 300, uo_out constant, no pulses; resumes 301 after run=1.
- 256 frames -> frame_count wraps 255->0 with frame_start asserted.
- rst_n pulled low at hpos=700, vpos=490 -> uo_out=8'h88 immediately, counters 0; restart yields identical first-line timing.
